// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param: the producer/consumer side
// drives requests through the master modport, and the FIFO answers through the slave modport.
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             wen;
  logic [WIDTH-1:0] wdata;
  logic             ren;
  logic             clr_err;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wen, wdata, ren, clr_err,
    input  rdata, rvalid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  flush, wen, wdata, ren, clr_err,
    output rdata, rvalid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with a registered read port, a fill count, almost-full and almost-empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                clk,
  input  logic                rst,
  sync_fifo_param_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic full, empty, wa, ra;

  // Status flags decode the registered count only, so they cannot glitch within a cycle.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign wa    = bus.wen & ~full  & ~bus.flush;
  assign ra    = bus.ren & ~empty & ~bus.flush;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      // Flush drops contents but keeps rdata and the error history intact.
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wa) wptr_d = wptr_q + AW'(1);
      if (ra) begin
        rptr_d   = rptr_q + AW'(1);
        rdata_d  = mem[rptr_q];
        rvalid_d = 1'b1;
      end
      if (wa && !ra)      count_d = count_q + CW'(1);
      else if (ra && !wa) count_d = count_q - CW'(1);
      if (bus.clr_err) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end else begin
        if (bus.wen && full)  overflow_d  = 1'b1;
        if (bus.ren && empty) underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wa) mem[wptr_q] <= bus.wdata;
  end

  assign bus.rdata        = rdata_q;
  assign bus.rvalid       = rvalid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
